// File: rtl/viterbi_pkg.sv
// viterbi_pkg
// Shared constants and types for the Viterbi decoder front end:
//   NUM_PAIRS / SYM_W / BM_W : frame geometry and branch metric width
//   FRAME_W / IDX_W          : derived frame width and symbol index width
//   state_t                  : sequencer FSM states {IDLE, RUN}
//   EXP_00 .. EXP_11         : expected encoder outputs of the rate-1/2 code
package viterbi_pkg;

  localparam int NUM_PAIRS = 8;
  localparam int SYM_W     = 2;
  localparam int BM_W      = 2;
  localparam int FRAME_W   = NUM_PAIRS * SYM_W;
  localparam int IDX_W     = $clog2(NUM_PAIRS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SYM_W-1:0] EXP_00 = 2'b00;
  localparam logic [SYM_W-1:0] EXP_01 = 2'b01;
  localparam logic [SYM_W-1:0] EXP_10 = 2'b10;
  localparam logic [SYM_W-1:0] EXP_11 = 2'b11;

endpackage

// File: rtl/hamming_bm.sv
// hamming_bm
// Combinational Hamming distance between a received symbol pair and one
// expected encoder output.
//   i_rx   : received symbol pair
//   i_exp  : expected encoder output
//   o_dist : number of differing bits (0..SYM_W)
module hamming_bm
  import viterbi_pkg::*;
(
  input  logic [SYM_W-1:0] i_rx,
  input  logic [SYM_W-1:0] i_exp,
  output logic [BM_W-1:0]  o_dist
);

  logic [SYM_W-1:0] w_diff;

  assign w_diff = i_rx ^ i_exp;

  always_comb begin
    o_dist = '0;
    for (int k = 0; k < SYM_W; k++) begin
      o_dist = o_dist + BM_W'(w_diff[k]);
    end
  end

endmodule

// File: rtl/branch_metric_sequencer.sv
// branch_metric_sequencer
// Snapshots one frame of NUM_PAIRS received symbol pairs from input_buffer
// and streams them, most significant pair first, to the ACS stage with a
// valid/ready handshake. Each streamed symbol carries four Hamming branch
// metrics. A one-cycle refresh pulse follows every capture so input_buffer
// can present its next frame.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   frame_valid               : input_buffer holds a valid frame
//   bit_pair_0 .. bit_pair_7  : received pairs (bit_pair_7 streamed first)
//   acs_ready                 : ACS accepts the current symbol
//   refresh                   : one-cycle pulse after each capture
//   sym_out, bm_00 .. bm_11   : current symbol and its branch metrics
//   bm_valid                  : sym_out / bm_* valid
//   sym_idx, frame_last       : trellis step in frame, last-symbol flag
// Optional build macro FRAME_CNT_EN adds frame_count[15:0], a wrapping count
// of completed frames.
module branch_metric_sequencer
  import viterbi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  logic [SYM_W-1:0] bit_pair_0,
  input  logic [SYM_W-1:0] bit_pair_1,
  input  logic [SYM_W-1:0] bit_pair_2,
  input  logic [SYM_W-1:0] bit_pair_3,
  input  logic [SYM_W-1:0] bit_pair_4,
  input  logic [SYM_W-1:0] bit_pair_5,
  input  logic [SYM_W-1:0] bit_pair_6,
  input  logic [SYM_W-1:0] bit_pair_7,
  output logic             refresh,
  output logic [SYM_W-1:0] sym_out,
  output logic [BM_W-1:0]  bm_00,
  output logic [BM_W-1:0]  bm_01,
  output logic [BM_W-1:0]  bm_10,
  output logic [BM_W-1:0]  bm_11,
  output logic             bm_valid,
  input  logic             acs_ready,
  output logic [IDX_W-1:0] sym_idx,
  output logic             frame_last
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam logic [SYM_W-1:0] EXP_TAB [4] = '{EXP_00, EXP_01, EXP_10, EXP_11};

  state_t             r_state;
  logic [FRAME_W-1:0] r_shadow;
  logic [IDX_W-1:0]   r_sym_idx;
  logic               r_bm_valid;
  logic               r_refresh;
  logic               r_frame_last;

  logic [FRAME_W-1:0] w_frame;
  logic [IDX_W-1:0]   w_idx_next;
  logic               w_xfer;
  logic [BM_W-1:0]    w_bm [4];

  assign w_frame    = {bit_pair_7, bit_pair_6, bit_pair_5, bit_pair_4,
                       bit_pair_3, bit_pair_2, bit_pair_1, bit_pair_0};
  assign w_idx_next = r_sym_idx + IDX_W'(1);
  assign w_xfer     = r_bm_valid & acs_ready;

  // The shadow register shifts left on every transfer, so the symbol being
  // presented is always its top pair.
  assign sym_out    = r_shadow[FRAME_W-1 -: SYM_W];
  assign bm_valid   = r_bm_valid;
  assign refresh    = r_refresh;
  assign sym_idx    = r_sym_idx;
  assign frame_last = r_frame_last;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bm
      hamming_bm u_bm (
        .i_rx   (sym_out),
        .i_exp  (EXP_TAB[gi]),
        .o_dist (w_bm[gi])
      );
    end
  endgenerate

  // Metrics read as zero whenever no symbol is being offered.
  assign bm_00 = r_bm_valid ? w_bm[0] : '0;
  assign bm_01 = r_bm_valid ? w_bm[1] : '0;
  assign bm_10 = r_bm_valid ? w_bm[2] : '0;
  assign bm_11 = r_bm_valid ? w_bm[3] : '0;

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_count;
  assign frame_count = r_frame_count;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_sym_idx    <= '0;
      r_bm_valid   <= 1'b0;
      r_refresh    <= 1'b0;
      r_frame_last <= 1'b0;
`ifdef FRAME_CNT_EN
      r_frame_count <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_bm_valid   <= 1'b0;
          r_refresh    <= 1'b0;
          r_frame_last <= 1'b0;
          r_sym_idx    <= '0;
          if (frame_valid) begin
            r_shadow   <= w_frame;
            r_bm_valid <= 1'b1;
            r_refresh  <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_refresh <= 1'b0;
          if (w_xfer) begin
            if (r_frame_last) begin
              r_state      <= IDLE;
              r_bm_valid   <= 1'b0;
              r_frame_last <= 1'b0;
              r_sym_idx    <= '0;
`ifdef FRAME_CNT_EN
              r_frame_count <= r_frame_count + 16'd1;
`endif
            end else begin
              r_shadow     <= {r_shadow[FRAME_W-SYM_W-1:0], {SYM_W{1'b0}}};
              r_sym_idx    <= w_idx_next;
              r_frame_last <= (w_idx_next == IDX_W'(NUM_PAIRS - 1));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_metric_sequencer.sv
// tb_branch_metric_sequencer
// Self-checking bench for branch_metric_sequencer: a metric table, directed
// multi-cycle sequences (stall, mid-run input change, mid-frame reset) and
// randomized traffic against a queue-based reference model.
// Build with FRAME_CNT_EN defined to also check frame_count.
module tb_branch_metric_sequencer;
  import viterbi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_valid;
  logic       acs_ready;
  logic [1:0] bp [8];
  logic       refresh;
  logic [1:0] sym_out;
  logic [1:0] bm_00, bm_01, bm_10, bm_11;
  logic       bm_valid;
  logic [2:0] sym_idx;
  logic       frame_last;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of symbols still to be delivered in this frame.
  logic [1:0] mq [$];
  logic       m_refresh = 1'b0;
  int         m_frames  = 0;

  typedef struct {
    logic [1:0] sym;
    int         e00, e01, e10, e11;
  } bm_vec_t;
  bm_vec_t tbl [4];

  always #5 clk = ~clk;

  branch_metric_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .bit_pair_0  (bp[0]),
    .bit_pair_1  (bp[1]),
    .bit_pair_2  (bp[2]),
    .bit_pair_3  (bp[3]),
    .bit_pair_4  (bp[4]),
    .bit_pair_5  (bp[5]),
    .bit_pair_6  (bp[6]),
    .bit_pair_7  (bp[7]),
    .refresh     (refresh),
    .sym_out     (sym_out),
    .bm_00       (bm_00),
    .bm_01       (bm_01),
    .bm_10       (bm_10),
    .bm_11       (bm_11),
    .bm_valid    (bm_valid),
    .acs_ready   (acs_ready),
    .sym_idx     (sym_idx),
    .frame_last  (frame_last)
`ifdef FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_frame(input logic [15:0] f);
    for (int i = 0; i < 8; i++) bp[i] = f[2*i +: 2];
  endtask

  task automatic model_update();
    if (rst) begin
      mq.delete();
      m_refresh = 1'b0;
      m_frames  = 0;
    end else if (mq.size() == 0) begin
      m_refresh = frame_valid;
      if (frame_valid)
        for (int i = 7; i >= 0; i--) mq.push_back(bp[i]);
    end else begin
      m_refresh = 1'b0;
      if (acs_ready) begin
        if (mq.size() == 1) m_frames++;
        void'(mq.pop_front());
      end
    end
  endtask

  task automatic check_outputs();
    logic [1:0] s;
    chk("bm_valid", int'(bm_valid), int'(mq.size() != 0));
    chk("refresh", int'(refresh), int'(m_refresh));
    if (mq.size() != 0) begin
      s = mq[0];
      chk("sym_out", int'(sym_out), int'(s));
      chk("sym_idx", int'(sym_idx), 8 - mq.size());
      chk("frame_last", int'(frame_last), int'(mq.size() == 1));
      chk("bm_00", int'(bm_00), $countones(s ^ 2'b00));
      chk("bm_01", int'(bm_01), $countones(s ^ 2'b01));
      chk("bm_10", int'(bm_10), $countones(s ^ 2'b10));
      chk("bm_11", int'(bm_11), $countones(s ^ 2'b11));
    end else begin
      chk("bm_idle", int'({bm_00, bm_01, bm_10, bm_11}), 0);
    end
`ifdef FRAME_CNT_EN
    chk("frame_count", int'(frame_count), m_frames & 16'hFFFF);
`endif
  endtask

  // Inputs are driven before calling; DUT and model both sample them at the
  // next rising edge, outputs are compared on the following falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_out(input int budget);
    int n = 0;
    while (mq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", int'(mq.size() != 0), 0);
  endtask

  logic [1:0] exp_a5 [8];
  logic [1:0] exp_5a [8];

  initial begin
    tbl[0] = '{2'b00, 0, 1, 1, 2};
    tbl[1] = '{2'b01, 1, 0, 2, 1};
    tbl[2] = '{2'b10, 1, 2, 0, 1};
    tbl[3] = '{2'b11, 2, 1, 1, 0};
    exp_a5 = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    exp_5a = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};

    rst = 1'b1; frame_valid = 1'b0; acs_ready = 1'b1;
    set_frame(16'h0000);
    @(negedge clk);
    step(); step();
    chk("rst_sym_out", int'(sym_out), 0);
    chk("rst_sym_idx", int'(sym_idx), 0);
    chk("rst_frame_last", int'(frame_last), 0);
    chk("rst_bm", int'({bm_00, bm_01, bm_10, bm_11}), 0);
    rst = 1'b0;
    step();

    // 0xA5A5 frame, ACS always ready.
    set_frame(16'hA5A5); frame_valid = 1'b1;
    step();
    $display("[TB] capture A5A5 refresh=%0d sym=%0d", refresh, sym_out);
    chk("a5_refresh", int'(refresh), 1);
    chk("a5_sym0", int'(sym_out), int'(exp_a5[0]));
    frame_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      chk("a5_seq", int'(sym_out), int'(exp_a5[k]));
      chk("a5_idx", int'(sym_idx), k);
    end
    chk("a5_last", int'(frame_last), 1);
    step();
    chk("a5_bubble", int'(bm_valid), 0);

    // Stall at idx 2, then change the pairs mid-run; next frame back-to-back.
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    step(); step();
    acs_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_sym", int'(sym_out), 2'b01);
      chk("stall_idx", int'(sym_idx), 2);
    end
    $display("[TB] stall released at idx %0d", sym_idx);
    acs_ready = 1'b1;
    set_frame(16'h5A5A);
    for (int k = 3; k < 8; k++) begin
      step();
      chk("stall_seq", int'(sym_out), int'(exp_a5[k]));
      chk("stall_idx_seq", int'(sym_idx), k);
    end
    frame_valid = 1'b1;
    step();
    chk("bubble", int'(bm_valid), 0);
    step();
    frame_valid = 1'b0;
    chk("5a_refresh", int'(refresh), 1);
    chk("5a_sym0", int'(sym_out), int'(exp_5a[0]));
    for (int k = 1; k < 8; k++) begin
      step();
      chk("5a_seq", int'(sym_out), int'(exp_5a[k]));
    end
    step();

    // Reset in the middle of a frame at idx 4.
    set_frame(16'hA5A5); frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("pre_rst_idx", int'(sym_idx), 4);
    rst = 1'b1;
    step();
    chk("rst_mid_valid", int'(bm_valid), 0);
    chk("rst_mid_refresh", int'(refresh), 0);
    step();
    rst = 1'b0; frame_valid = 1'b1;
    step();
    chk("restart_idx", int'(sym_idx), 0);
    chk("restart_valid", int'(bm_valid), 1);
    frame_valid = 1'b0;
    run_out(40);
    step();

    // Branch metric table: a frame of identical symbols per entry.
    for (int t = 0; t < 4; t++) begin
      set_frame({8{tbl[t].sym}}); frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      $display("[TB] table sym=%0d bm=%0d/%0d/%0d/%0d", tbl[t].sym, bm_00, bm_01, bm_10, bm_11);
      chk("tbl_bm_00", int'(bm_00), tbl[t].e00);
      chk("tbl_bm_01", int'(bm_01), tbl[t].e01);
      chk("tbl_bm_10", int'(bm_10), tbl[t].e10);
      chk("tbl_bm_11", int'(bm_11), tbl[t].e11);
      run_out(40);
      step();
    end

`ifdef FRAME_CNT_EN
    // Three back-to-back frames after a fresh reset.
    rst = 1'b1; step(); rst = 1'b0;
    frame_valid = 1'b1; acs_ready = 1'b1;
    for (int k = 0; k < 27; k++) step();
    frame_valid = 1'b0;
    run_out(40);
    chk("frame_count_3", int'(frame_count), 3);
`endif

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      frame_valid = ($urandom_range(0, 1) == 1);
      acs_ready   = ($urandom_range(0, 9) < 7);
      set_frame(16'($urandom));
      step();
    end
    rst = 1'b0; acs_ready = 1'b1; frame_valid = 1'b0;
    run_out(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
